// File: rtl/dcache_direct_wb_if.sv
// dcache_direct_wb_if
//   Bundles the pipeline-side D-cache request and the line-refill/write-back
//   handshake to the next memory level.
//   Ports (signals):
//     proc_read/proc_write/proc_addr[29:0]/proc_wdata[31:0] : pipeline request
//     proc_stall/proc_rdata[31:0]                           : cache response
//     mem_read/mem_write/mem_addr[27:0]/mem_wdata[127:0]    : line request
//     mem_rdata[127:0]/mem_ready                            : line response
//   Modports: slave = the cache, master = pipeline + memory side driver.
interface dcache_direct_wb_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_direct_wb.sv
// dcache_direct_wb
//   Direct-mapped, write-back, write-allocate L1 data cache with 4-word lines.
//   Hits complete in the request cycle; misses stall the pipeline while a
//   dirty victim is written back (WRITEBACK) and the line is refilled
//   (ALLOCATE).
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset (clears valid/dirty, FSM to IDLE)
//     bus   : dcache_direct_wb_if.slave (pipeline request + memory handshake)
module dcache_direct_wb #(
  parameter int INDEX_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  dcache_direct_wb_if.slave   bus
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 28 - INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  state_t state_r;
  state_t state_s;

  logic [LINES-1:0] valid_r;
  logic [LINES-1:0] dirty_r;
  logic [TAG_W-1:0] tag_r  [LINES];
  logic [127:0]     data_r [LINES];

  logic [1:0]         req_off_s;
  logic [INDEX_W-1:0] req_idx_s;
  logic [TAG_W-1:0]   req_tag_s;
  logic               req_s;
  logic               hit_s;
  logic [127:0]       line_s;

  logic               wr_hit_s;
  logic               refill_s;
  logic               stall_s;
  logic [31:0]        rdata_s;
  logic               mem_read_s;
  logic               mem_write_s;
  logic [27:0]        mem_addr_s;
  logic [127:0]       mem_wdata_s;

  assign req_off_s = bus.proc_addr[1:0];
  assign req_idx_s = bus.proc_addr[INDEX_W+1:2];
  assign req_tag_s = bus.proc_addr[29:INDEX_W+2];
  assign req_s     = bus.proc_read | bus.proc_write;
  assign line_s    = data_r[req_idx_s];
  assign hit_s     = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic, hit/miss handling and memory handshake outputs
  always_comb begin
    state_s     = state_r;
    wr_hit_s    = 1'b0;
    refill_s    = 1'b0;
    stall_s     = 1'b0;
    rdata_s     = 32'd0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    mem_addr_s  = 28'd0;
    mem_wdata_s = 128'd0;
    case (state_r)
      S_IDLE: begin
        if (req_s) begin
          if (hit_s) begin
            // A simultaneous read+write is serviced as a write.
            if (bus.proc_write) begin
              wr_hit_s = 1'b1;
            end else begin
              rdata_s = line_s[{req_off_s, 5'd0} +: 32];
            end
          end else begin
            stall_s = 1'b1;
            if (valid_r[req_idx_s] && dirty_r[req_idx_s]) begin
              state_s = S_WRITEBACK;
            end else begin
              state_s = S_ALLOCATE;
            end
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WRITEBACK: begin
        stall_s     = 1'b1;
        mem_write_s = 1'b1;
        mem_addr_s  = {tag_r[req_idx_s], req_idx_s};
        mem_wdata_s = line_s;
        if (bus.mem_ready) begin
          state_s = S_ALLOCATE;
        end else begin
          state_s = S_WRITEBACK;
        end
      end
      S_ALLOCATE: begin
        stall_s    = 1'b1;
        mem_read_s = 1'b1;
        mem_addr_s = bus.proc_addr[29:2];
        if (bus.mem_ready) begin
          refill_s = 1'b1;
          state_s  = S_IDLE;
        end else begin
          state_s  = S_ALLOCATE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // While reset is held the pipeline request may still be present; keep the
  // response quiet so stall does not reflect the (now invalid) lookup.
  assign bus.proc_stall = stall_s & rst_n;
  assign bus.proc_rdata = rst_n ? rdata_s : 32'd0;
  assign bus.mem_read   = mem_read_s;
  assign bus.mem_write  = mem_write_s;
  assign bus.mem_addr   = mem_addr_s;
  assign bus.mem_wdata  = mem_wdata_s;

  // Valid/dirty bookkeeping: refill installs a clean line, write hit dirties it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else if (refill_s) begin
      valid_r[req_idx_s] <= 1'b1;
      dirty_r[req_idx_s] <= 1'b0;
    end else if (wr_hit_s) begin
      dirty_r[req_idx_s] <= 1'b1;
    end else begin
      valid_r <= valid_r;
      dirty_r <= dirty_r;
    end
  end

  // Tag and data arrays; contents are qualified by valid, so no reset needed
  always_ff @(posedge clk) begin
    if (refill_s) begin
      data_r[req_idx_s] <= bus.mem_rdata;
      tag_r[req_idx_s]  <= req_tag_s;
    end else if (wr_hit_s) begin
      data_r[req_idx_s][{req_off_s, 5'd0} +: 32] <= bus.proc_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_direct_wb.sv
// tb_dcache_direct_wb
//   Randomized and directed self-checking bench for dcache_direct_wb.
//   The reference model treats the cache as a transparent word memory and
//   predicts hit/miss, write-back and stall length from per-line
//   valid/dirty/tag bookkeeping.
module tb_dcache_direct_wb;

  logic clk;
  logic rst_n;
  dcache_direct_wb_if bus ();

  dcache_direct_wb #(.INDEX_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: line bookkeeping plus processor / next-level word views
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [24:0] m_tag   [8];
  logic [31:0] ref_word [logic [29:0]];   // latest processor-visible values
  logic [31:0] ref_mem  [logic [29:0]];   // values held by next level
  // Memory responder contents (written only by observed write-backs)
  logic [127:0] backing [logic [27:0]];

  function automatic logic [31:0] init_word(input logic [29:0] a);
    logic [31:0] ext;
    ext = {2'b00, a};
    return (ext * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] view_word(input logic [29:0] a);
    if (ref_word.exists(a)) return ref_word[a];
    if (ref_mem.exists(a))  return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [127:0] view_line(input logic [27:0] l);
    return {view_word({l, 2'd3}), view_word({l, 2'd2}),
            view_word({l, 2'd1}), view_word({l, 2'd0})};
  endfunction

  function automatic logic [127:0] backing_line(input logic [27:0] l);
    if (backing.exists(l)) return backing[l];
    return {init_word({l, 2'd3}), init_word({l, 2'd2}),
            init_word({l, 2'd1}), init_word({l, 2'd0})};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    ref_word.delete();   // dirty data not yet written back is lost
  endtask

  // One pipeline access held until the cache stops stalling; acts as memory.
  task automatic do_access(input logic rd, input logic wr, input logic [29:0] addr,
                           input logic [31:0] wdata, input int lat_wb, input int lat_al);
    logic [2:0]   idx;
    logic [24:0]  tag;
    bit           hit, exp_wb, done;
    logic [27:0]  wb_addr;
    logic [127:0] wb_data;
    logic [31:0]  exp_rdata;
    int           exp_stall, stall_cnt, wb_cnt, al_cnt;
    idx       = addr[4:2];
    tag       = addr[29:5];
    hit       = m_valid[idx] && (m_tag[idx] == tag);
    exp_wb    = !hit && m_valid[idx] && m_dirty[idx];
    wb_addr   = {m_tag[idx], idx};
    wb_data   = view_line(wb_addr);
    exp_stall = hit ? 0 : (1 + lat_al + (exp_wb ? lat_wb : 0));
    if (exp_wb) begin
      for (int w = 0; w < 4; w++) ref_mem[{wb_addr, w[1:0]}] = wb_data[w*32 +: 32];
    end
    exp_rdata = wr ? 32'd0 : view_word(addr);
    bus.proc_read  = rd;
    bus.proc_write = wr;
    bus.proc_addr  = addr;
    bus.proc_wdata = wdata;
    stall_cnt = 0; wb_cnt = 0; al_cnt = 0; done = 1'b0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (bus.mem_read && bus.mem_write) begin
        n_fail++;
        $display("FAIL overlap addr=%h: mem_read and mem_write both high", addr);
      end
      if (!bus.proc_stall) begin
        done = 1'b1;
        n_checks++;
        if (stall_cnt !== exp_stall) begin
          n_fail++;
          $display("FAIL stall_cycles addr=%h: got %0d expected %0d", addr, stall_cnt, exp_stall);
        end
        n_checks++;
        if (bus.proc_rdata !== exp_rdata) begin
          n_fail++;
          $display("FAIL rdata addr=%h: got %h expected %h", addr, bus.proc_rdata, exp_rdata);
        end
      end else begin
        stall_cnt++;
        if (bus.mem_write) begin
          wb_cnt++;
          n_checks++;
          if (!exp_wb || al_cnt != 0) begin
            n_fail++;
            $display("FAIL wb_unexpected addr=%h: mem_write seen, expected_wb=%0d after %0d refill cycles",
                     addr, exp_wb, al_cnt);
          end
          n_checks++;
          if (bus.mem_addr !== wb_addr || bus.mem_wdata !== wb_data) begin
            n_fail++;
            $display("FAIL wb_line addr=%h: got %h/%h expected %h/%h", addr,
                     bus.mem_addr, bus.mem_wdata, wb_addr, wb_data);
          end
          if (wb_cnt == lat_wb) begin
            bus.mem_ready = 1'b1;
            backing[bus.mem_addr] = bus.mem_wdata;
          end
        end else if (bus.mem_read) begin
          al_cnt++;
          n_checks++;
          if (bus.mem_addr !== addr[29:2] || (exp_wb && wb_cnt < lat_wb)) begin
            n_fail++;
            $display("FAIL refill_addr addr=%h: got %h expected %h (wb cycles %0d)",
                     addr, bus.mem_addr, addr[29:2], wb_cnt);
          end
          bus.mem_rdata = backing_line(bus.mem_addr);
          if (al_cnt == lat_al) bus.mem_ready = 1'b1;
        end
        @(posedge clk);
        #1 bus.mem_ready = 1'b0;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout addr=%h: still stalled after 64 cycles, expected %0d", addr, exp_stall);
    end
    @(posedge clk);
    #1;
    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      m_dirty[idx]   = 1'b1;
      ref_word[addr] = wdata;
    end
  endtask

  task automatic check_quiet(input string name);
    n_checks++;
    if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== 32'd0 || bus.mem_read !== 1'b0 ||
        bus.mem_write !== 1'b0 || bus.mem_addr !== 28'd0 || bus.mem_wdata !== 128'd0) begin
      n_fail++;
      $display("FAIL %s: stall=%b rdata=%h mr=%b mw=%b maddr=%h mwdata=%h expected all zero",
               name, bus.proc_stall, bus.proc_rdata, bus.mem_read, bus.mem_write,
               bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.proc_read = 1'b0; bus.proc_write = 1'b0;
    bus.proc_addr = 30'd0; bus.proc_wdata = 32'd0;
    bus.mem_rdata = 128'd0; bus.mem_ready = 1'b0;
    model_reset();
    #1 check_quiet("reset_held");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check_quiet("after_reset");
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    backing[28'h4] = {32'd4, 32'd3, 32'd2, 32'd1};
    for (int w = 0; w < 4; w++) ref_mem[30'h10 + w] = w + 1;
    do_access(1'b1, 1'b0, 30'h10, 32'd0, 1, 3);          // clean miss, 4 stalls, rdata 1
    do_access(1'b0, 1'b1, 30'h13, 32'hDEAD_BEEF, 1, 1);  // write hit
    do_access(1'b1, 1'b0, 30'h13, 32'd0, 1, 1);          // read back
    do_access(1'b1, 1'b0, 30'h30, 32'd0, 2, 2);          // dirty eviction of line 4
    n_checks++;
    if (backing[28'h4][127:96] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL wb_word3: got %h expected deadbeef", backing[28'h4][127:96]);
    end
  endtask

  task automatic test_single_cycle();
    do_access(1'b1, 1'b0, 30'h08, 32'd0, 1, 1);          // 2 stall cycles
    do_access(1'b1, 1'b0, 30'h0B, 32'd0, 1, 1);          // same line now hits
  endtask

  task automatic test_idle();
    bus.proc_read = 1'b0; bus.proc_write = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = $urandom_range(0, 1);
      @(negedge clk);
      check_quiet("idle");
      @(posedge clk);
      #1 bus.mem_ready = 1'b0;
    end
    do_access(1'b1, 1'b0, 30'h31, 32'd0, 1, 1);          // line 4 still resident
  endtask

  task automatic test_reset_mid_alloc();
    bus.proc_read = 1'b1; bus.proc_write = 1'b0;
    bus.proc_addr = 30'h5C; bus.proc_wdata = 32'd0;
    @(negedge clk);
    n_checks++;
    if (bus.proc_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_alloc_miss: stall=%b expected 1", bus.proc_stall);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (bus.mem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_alloc_read: mem_read=%b expected 1", bus.mem_read);
    end
    #1 rst_n = 1'b0;
    #1 check_quiet("reset_in_allocate");
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    do_access(1'b1, 1'b0, 30'h5C, 32'd0, 1, 2);          // misses again
    do_access(1'b1, 1'b0, 30'h30, 32'd0, 1, 1);          // line 4 also invalidated
  endtask

  task automatic test_random();
    logic [29:0] a;
    int          r;
    for (int i = 0; i < 250; i++) begin
      a = {$urandom_range(0, 3), 5'd0} | 30'($urandom_range(0, 31));
      r = $urandom_range(0, 9);
      do_access(r < 5 || r == 9, r >= 5, a, $urandom,
                $urandom_range(1, 3), $urandom_range(1, 3));
    end
  endtask

  task automatic test_back_to_back();
    // Fill then hammer one line with consecutive hits, then evict by tag.
    do_access(1'b0, 1'b1, 30'h41, 32'h1111_0001, 1, 1);
    for (int i = 0; i < 4; i++) do_access(1'b0, 1'b1, 30'h40 + i, 32'hA5A5_0000 + i, 1, 1);
    for (int i = 0; i < 4; i++) do_access(1'b1, 1'b0, 30'h40 + i, 32'd0, 1, 1);
    do_access(1'b1, 1'b0, 30'h60, 32'd0, 1, 1);          // same index, new tag
    do_access(1'b1, 1'b0, 30'h42, 32'd0, 3, 1);          // brings written data back
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_single_cycle();
    test_idle();
    test_reset_mid_alloc();
    test_back_to_back();
    test_random();
    bus.proc_read = 1'b0; bus.proc_write = 1'b0;
    @(negedge clk);
    check_quiet("final_idle");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
